// File: rtl/spi_byte_master_if.sv
// Byte-level handshake between the AXI-Lite register file and the SPI byte engine.
// The master modport is the requester; the slave modport is the engine.
interface spi_byte_master_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       cs_hold;
    logic       cs_release;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;

    modport master (
        output tx_data, tx_valid, cs_hold, cs_release,
        input  tx_ready, rx_data, rx_valid, busy
    );

    modport slave (
        input  tx_data, tx_valid, cs_hold, cs_release,
        output tx_ready, rx_data, rx_valid, busy
    );
endinterface

// File: rtl/spi_byte_master.sv
// SPI mode-0 byte engine: shifts one byte MSB-first on MOSI while capturing MISO,
// optionally holding chip-select low across bytes of a multi-byte command.
module spi_byte_master #(
    parameter int unsigned ClkDiv = 10
) (
    input  logic             aclk_i,
    input  logic             aresetn_i,
    spi_byte_master_if.slave bus,
    output logic             spi_sck_o,
    output logic             spi_mosi_o,
    input  logic             spi_miso_i,
    output logic             spi_cs_o
);
    typedef enum logic [2:0] {StIdle, StSetup, StSckHi, StSckLo, StHold, StGap} state_e;

    localparam logic [7:0] PhaseLast = 8'(ClkDiv - 1);

    state_e     state_q;
    logic [7:0] phase_q;
    logic [6:0] tx_sr_q;
    logic [6:0] rx_sr_q;
    logic [7:0] rx_data_q;
    logic [2:0] bit_q;
    logic       hold_q;
    logic       rx_valid_q;
    logic       tx_ready_q;
    logic       busy_q;
    logic       sck_q;
    logic       mosi_q;
    logic       cs_q;
    logic       phase_end;
    logic       accept;

    assign phase_end = (phase_q == PhaseLast);
    // tx_ready_q is only ever set in IDLE and HOLD, so it alone qualifies an accept.
    assign accept    = bus.tx_valid && tx_ready_q;

    always_ff @(posedge aclk_i) begin
        if (!aresetn_i) begin
            state_q    <= StIdle;
            phase_q    <= '0;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            rx_data_q  <= '0;
            bit_q      <= '0;
            hold_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            tx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            sck_q      <= 1'b0;
            mosi_q     <= 1'b0;
            cs_q       <= 1'b1;
        end else begin
            rx_valid_q <= 1'b0;
            if (accept) begin
                state_q    <= StSetup;
                phase_q    <= '0;
                bit_q      <= '0;
                tx_sr_q    <= bus.tx_data[6:0];
                mosi_q     <= bus.tx_data[7];
                hold_q     <= bus.cs_hold;
                cs_q       <= 1'b0;
                tx_ready_q <= 1'b0;
                busy_q     <= 1'b1;
            end else begin
                unique case (state_q)
                    StIdle: tx_ready_q <= 1'b1;
                    StHold: begin
                        if (bus.cs_release) begin
                            state_q    <= StGap;
                            cs_q       <= 1'b1;
                            tx_ready_q <= 1'b0;
                        end
                    end
                    StSetup, StSckLo: begin
                        if (phase_end) begin
                            state_q <= StSckHi;
                            phase_q <= '0;
                            sck_q   <= 1'b1;
                        end else begin
                            phase_q <= phase_q + 8'd1;
                        end
                    end
                    StSckHi: begin
                        if (phase_end) begin
                            phase_q <= '0;
                            sck_q   <= 1'b0;
                            bit_q   <= bit_q + 3'd1;
                            rx_sr_q <= {rx_sr_q[5:0], spi_miso_i};
                            if (bit_q == 3'd7) begin
                                // Last bit: no trailing low phase, go straight to HOLD/GAP.
                                rx_data_q  <= {rx_sr_q, spi_miso_i};
                                rx_valid_q <= 1'b1;
                                if (hold_q) begin
                                    state_q    <= StHold;
                                    tx_ready_q <= 1'b1;
                                end else begin
                                    state_q <= StGap;
                                    cs_q    <= 1'b1;
                                end
                            end else begin
                                state_q <= StSckLo;
                                mosi_q  <= tx_sr_q[6];
                                tx_sr_q <= {tx_sr_q[5:0], 1'b0};
                            end
                        end else begin
                            phase_q <= phase_q + 8'd1;
                        end
                    end
                    StGap: begin
                        if (phase_end) begin
                            state_q    <= StIdle;
                            phase_q    <= '0;
                            busy_q     <= 1'b0;
                            tx_ready_q <= 1'b1;
                        end else begin
                            phase_q <= phase_q + 8'd1;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign bus.tx_ready = tx_ready_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.busy     = busy_q;
    assign spi_sck_o    = sck_q;
    assign spi_mosi_o   = mosi_q;
    assign spi_cs_o     = cs_q;

endmodule

// File: tb/tb_spi_byte_master.sv
// Scoreboard bench for spi_byte_master: DUT A (divider 2) talks to a small EEPROM model,
// DUT B (divider 3) runs with MISO looped back to MOSI.
module tb_spi_byte_master;
    localparam int unsigned DivA = 2;
    localparam int unsigned DivB = 3;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    spi_byte_master_if a_if ();
    spi_byte_master_if b_if ();
    logic a_sck, a_mosi, a_cs;
    logic b_sck, b_mosi, b_cs;
    logic ee_miso = 1'b0;

    spi_byte_master #(.ClkDiv(DivA)) dut_a (
        .aclk_i     (aclk),
        .aresetn_i  (aresetn),
        .bus        (a_if),
        .spi_sck_o  (a_sck),
        .spi_mosi_o (a_mosi),
        .spi_miso_i (ee_miso),
        .spi_cs_o   (a_cs)
    );

    spi_byte_master #(.ClkDiv(DivB)) dut_b (
        .aclk_i     (aclk),
        .aresetn_i  (aresetn),
        .bus        (b_if),
        .spi_sck_o  (b_sck),
        .spi_mosi_o (b_mosi),
        .spi_miso_i (b_mosi),
        .spi_cs_o   (b_cs)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // EEPROM model: mode 0, samples MOSI on SCK rise, drives MISO after SCK fall.
    logic [7:0] ee_mem [256];
    logic [7:0] ee_in = '0, ee_op = '0, ee_out = '0, ee_addr = '0;
    int ee_bits = 0, ee_idx = 0;
    logic ee_wel = 1'b0;

    always @(posedge a_cs or negedge a_cs or posedge a_sck or negedge a_sck) begin
        if (a_cs) begin
            if (ee_op == 8'h02 && ee_idx >= 3) ee_wel = 1'b0;
            ee_bits = 0; ee_idx = 0; ee_op = '0; ee_out = '0; ee_miso = 1'b0;
        end else if (a_sck) begin
            ee_in = {ee_in[6:0], a_mosi};
            ee_bits++;
            if (ee_bits == 8) begin
                ee_bits = 0;
                if (ee_idx == 0) begin
                    ee_op = ee_in;
                    if (ee_in == 8'h06) ee_wel = 1'b1;
                end else if (ee_idx == 2) begin
                    ee_addr = ee_in;
                end else if (ee_idx > 2 && ee_op == 8'h02 && ee_wel) begin
                    ee_mem[ee_addr] = ee_in;
                    ee_addr++;
                end
                if (ee_op == 8'h03 && ee_idx >= 2) begin
                    ee_out = ee_mem[ee_addr];
                    ee_addr++;
                end
                ee_idx++;
            end
        end else begin
            ee_miso = ee_out[7];
            ee_out  = {ee_out[6:0], 1'b0};
        end
    end

    logic [7:0] mosi_cap = '0;
    int rises = 0;
    int cs_rises = 0;
    always @(posedge a_sck) begin
        mosi_cap = {mosi_cap[6:0], a_mosi};
        rises++;
    end
    always @(posedge a_cs) cs_rises++;

    typedef struct {
        logic [7:0] tx;
        logic [7:0] rx;
        int         acc;
    } exp_t;
    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea, eb;
    int last_rises = 0;
    logic prev_rxv_a = 1'b0;

    always @(negedge aclk) begin
        if (!aresetn) begin
            q_a.delete();
            last_rises = rises;
        end else if (a_if.rx_valid) begin
            check("rx_valid_one_cycle", prev_rxv_a, 1'b0);
            if (q_a.size() == 0) begin
                check("rx_valid_unexpected", a_if.rx_data, 32'hDEAD);
            end else begin
                ea = q_a.pop_front();
                check("rx_data", a_if.rx_data, ea.rx);
                check("mosi_byte", mosi_cap, ea.tx);
                check("sck_rises", rises - last_rises, 8);
                check("rx_latency", cyc - ea.acc, 16 * DivA);
            end
            last_rises = rises;
        end
        prev_rxv_a = a_if.rx_valid;
    end

    always @(negedge aclk) begin
        if (!aresetn) begin
            q_b.delete();
        end else if (b_if.rx_valid) begin
            if (q_b.size() == 0) begin
                check("b_rx_valid_unexpected", b_if.rx_data, 32'hDEAD);
            end else begin
                eb = q_b.pop_front();
                check("b_loopback_rx", b_if.rx_data, eb.rx);
                check("b_rx_latency", cyc - eb.acc, 16 * DivB);
            end
        end
    end

    task automatic send_a(input logic [7:0] d, input logic hold, input logic rel,
                          input logic [7:0] exp_rx);
        int n = 0;
        while (!a_if.tx_ready && n < 500) begin
            @(negedge aclk);
            n++;
        end
        check("tx_ready_wait", n < 500, 1'b1);
        a_if.tx_data = d; a_if.tx_valid = 1'b1; a_if.cs_hold = hold; a_if.cs_release = rel;
        @(negedge aclk);
        q_a.push_back('{tx: d, rx: exp_rx, acc: cyc});
        a_if.tx_valid = 1'b0; a_if.cs_release = 1'b0;
        check("accepted", {a_if.busy, a_if.tx_ready, a_cs}, 3'b100);
    endtask

    task automatic send_b(input logic [7:0] d);
        int n = 0;
        while (!b_if.tx_ready && n < 500) begin
            @(negedge aclk);
            n++;
        end
        check("b_tx_ready_wait", n < 500, 1'b1);
        b_if.tx_data = d; b_if.tx_valid = 1'b1;
        @(negedge aclk);
        q_b.push_back('{tx: d, rx: d, acc: cyc});
        b_if.tx_valid = 1'b0;
    endtask

    task automatic wait_idle_a();
        int n = 0;
        while (!(a_if.tx_ready && !a_if.busy) && n < 500) begin
            @(negedge aclk);
            n++;
        end
        check("idle_wait", n < 500, 1'b1);
    endtask

    logic [7:0] wr_seq [5] = '{8'h02, 8'h00, 8'hF0, 8'hAA, 8'hF0};
    logic [7:0] rd_seq [5] = '{8'h03, 8'h00, 8'hF0, 8'h00, 8'h00};
    logic [7:0] rd_exp [5] = '{8'h00, 8'h00, 8'h00, 8'hAA, 8'hF0};

    initial begin
        int n, k, c0, r0;
        a_if.tx_data = '0; a_if.tx_valid = 1'b0; a_if.cs_hold = 1'b0; a_if.cs_release = 1'b0;
        b_if.tx_data = '0; b_if.tx_valid = 1'b0; b_if.cs_hold = 1'b0; b_if.cs_release = 1'b0;

        repeat (3) @(negedge aclk);
        check("reset_outputs", {a_cs, a_sck, a_mosi, a_if.rx_valid, a_if.busy, a_if.tx_ready},
              6'b100000);
        check("reset_rx_data", a_if.rx_data, 8'h00);
        aresetn = 1'b1;
        @(negedge aclk);
        check("tx_ready_after_reset", a_if.tx_ready, 1'b1);

        // WREN with hold 0: CS low 32 cycles, then 2 gap cycles before ready.
        send_a(8'h06, 1'b0, 1'b0, 8'h00);
        n = 0;
        while (a_cs == 1'b0 && n < 100) begin
            n++;
            @(negedge aclk);
        end
        check("cs_low_cycles", n, 32);
        check("rx_valid_at_cs_rise", a_if.rx_valid, 1'b1);
        @(negedge aclk);
        check("gap_cs_ready", {a_cs, a_if.tx_ready}, 2'b10);
        @(negedge aclk);
        check("ready_after_gap", {a_cs, a_if.tx_ready, a_if.busy}, 3'b110);

        send_b(8'hA5);
        send_b(8'h5A);
        repeat (120) @(negedge aclk);
        check("b_all_rx_seen", q_b.size(), 0);
        check("b_bus_idle", {b_cs, b_sck}, 2'b10);

        c0 = cs_rises;
        for (int i = 0; i < 5; i++) send_a(wr_seq[i], i != 4, 1'b0, 8'h00);
        wait_idle_a();
        check("write_cs_rises", cs_rises - c0, 1);
        repeat (20) @(negedge aclk);
        check("ee_mem_f0", ee_mem[8'hF0], 8'hAA);
        check("ee_mem_f1", ee_mem[8'hF1], 8'hF0);

        c0 = cs_rises;
        for (int i = 0; i < 5; i++) send_a(rd_seq[i], i != 4, 1'b0, rd_exp[i]);
        wait_idle_a();
        check("read_cs_rises", cs_rises - c0, 1);
        check("read_rx_final", a_if.rx_data, 8'hF0);

        // Reset after the third SCK rise of 0xFF.
        r0 = rises;
        send_a(8'hFF, 1'b0, 1'b0, 8'h00);
        n = 0;
        while (rises - r0 < 3 && n < 100) begin
            @(negedge aclk);
            n++;
        end
        check("third_rise_wait", n < 100, 1'b1);
        aresetn = 1'b0;
        @(negedge aclk);
        check("midreset_bus", {a_cs, a_sck, a_if.rx_valid, a_if.busy}, 4'b1000);
        check("midreset_rx_data", a_if.rx_data, 8'h00);
        @(negedge aclk);
        aresetn = 1'b1;
        send_a(8'h81, 1'b0, 1'b0, 8'h00);
        wait_idle_a();

        // Accept and release in the same HOLD cycle: accept wins.
        send_a(8'h11, 1'b1, 1'b0, 8'h00);
        c0 = cs_rises;
        send_a(8'h3C, 1'b1, 1'b1, 8'h00);
        n = 0;
        while (!a_if.tx_ready && n < 200) begin
            @(negedge aclk);
            n++;
        end
        check("hold_reached", n < 200, 1'b1);
        check("hold_state", {a_cs, a_if.busy, a_sck}, 3'b010);
        check("hold_no_cs_rise", cs_rises - c0, 0);
        a_if.cs_release = 1'b1;
        @(negedge aclk);
        a_if.cs_release = 1'b0;
        n = 0; k = 0;
        while (!a_if.tx_ready && k < 50) begin
            if (a_cs) n++;
            @(negedge aclk);
            k++;
        end
        check("release_cs_high", n, DivA);
        check("release_idle", {a_if.busy, a_cs}, 2'b01);

        // Request while busy is dropped.
        send_a(8'h42, 1'b0, 1'b0, 8'h00);
        repeat (5) @(negedge aclk);
        check("busy_not_ready", a_if.tx_ready, 1'b0);
        a_if.tx_data = 8'h99; a_if.tx_valid = 1'b1;
        @(negedge aclk);
        a_if.tx_valid = 1'b0;
        wait_idle_a();
        repeat (40) @(negedge aclk);
        check("no_extra_rx", q_a.size(), 0);
        check("no_extra_sck", rises - last_rises, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end
endmodule
